// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses MAGIC/LEN/DATA[/CSUM] byte frames into 32-bit imem writes and holds the CPU until an image loads.
// Optional feature macro BOOT_CHECKSUM_EN: adds the trailing XOR checksum byte and CSUM state.
module uart_boot_loader #(
    parameter int          ADDR_WIDTH     = 10,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  boot_done,
    output logic                  boot_error,
    output logic [15:0]           words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
`ifdef BOOT_CHECKSUM_EN
    localparam state_t TAIL = CSUM;
`else
    localparam state_t TAIL = DONE;
`endif
    localparam int          TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] CAP = 17'(2 ** ADDR_WIDTH);

    state_t                state, next_state;
    logic [7:0]            len_lo;
    logic [15:0]           n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           word;
    logic [1:0]            byte_idx;
    logic [TW-1:0]         idle_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic        active, start, last, take;
    logic [15:0] len;
    assign active = state inside {LEN_LO, LEN_HI, DATA, CSUM};
    assign start  = state inside {IDLE, DONE, ERR} && rx_valid && rx_data == MAGIC;
    assign last   = state == DATA && imem_we && words_loaded == n;
    assign take   = state == DATA && rx_valid;
    assign len    = {rx_data, len_lo};

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode; an idle timeout inside a frame overrides everything
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = LEN_LO;
            LEN_LO: if (rx_valid) next_state = LEN_HI;
            LEN_HI: if (rx_valid) next_state = ({1'b0, len} > CAP) ? ERR : (len == 16'd0 ? TAIL : DATA);
            DATA:   if (last) next_state = TAIL;
`ifdef BOOT_CHECKSUM_EN
            CSUM:   if (rx_valid) next_state = (rx_data == csum) ? DONE : ERR;
`endif
            default: next_state = IDLE;
        endcase
        if (active && !rx_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) next_state = ERR;
    end

    // Datapath: word assembly, imem write strobe and status flags registered from the entered state
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            boot_done    <= 1'b0;
            boot_error   <= 1'b0;
            words_loaded <= '0;
            len_lo       <= '0;
            n            <= '0;
            addr         <= '0;
            word         <= '0;
            byte_idx     <= '0;
            idle_cnt     <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            imem_we    <= 1'b0;
            cpu_hold   <= next_state != DONE;
            boot_done  <= next_state == DONE;
            boot_error <= next_state == ERR;
            idle_cnt   <= (active && !rx_valid) ? idle_cnt + 1'b1 : '0;
            if (start) begin
                words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (state == LEN_LO && rx_valid) len_lo <= rx_data;
            if (state == LEN_HI && rx_valid) begin
                n        <= len;
                addr     <= '0;
                byte_idx <= '0;
            end
            if (take) begin
                word     <= {rx_data, word[31:8]};
                byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
                if (byte_idx == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_addr    <= addr;
                    imem_wdata   <= {rx_data, word[31:8]};
                    addr         <= addr + 1'b1;
                    words_loaded <= words_loaded + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frame tests for uart_boot_loader (checksum tests enabled with BOOT_CHECKSUM_EN).
module tb_uart_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold, boot_done, boot_error;
    logic [15:0] words_loaded;

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int base;
    logic [31:0] mem [0:1023];

    uart_boot_loader #(.ADDR_WIDTH(10), .MAGIC(8'hA5), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .boot_done(boot_done), .boot_error(boot_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Model of the instruction memory fed by the write port
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", imem_we); end
        n_chk++; if (imem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        n_chk++; if (imem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
        n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
        n_chk++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", boot_done); end
        n_chk++; if (boot_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", boot_error); end
        n_chk++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_loaded); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load;
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h2A);
`endif
        n_chk++; if (we_cnt - base !== 2) begin n_fail++; $display("FAIL load_we_pulses got %0d want 2", we_cnt - base); end
        n_chk++; if (mem[0] !== 32'h12345678) begin n_fail++; $display("FAIL load_mem0 got %h want 12345678", mem[0]); end
        n_chk++; if (mem[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_mem1 got %h want deadbeef", mem[1]); end
        n_chk++; if (boot_done !== 1'b1) begin n_fail++; $display("FAIL load_done got %b want 1", boot_done); end
        n_chk++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL load_hold got %b want 0", cpu_hold); end
        n_chk++; if (boot_error !== 1'b0) begin n_fail++; $display("FAIL load_error got %b want 0", boot_error); end
        n_chk++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL load_words got %0d want 2", words_loaded); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_bad_csum;
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        send_byte(8'h00);
        n_chk++; if (boot_error !== 1'b1) begin n_fail++; $display("FAIL csum_error got %b want 1", boot_error); end
        n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_hold got %b want 1", cpu_hold); end
        n_chk++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL csum_done got %b want 0", boot_done); end
        n_chk++; if (we_cnt - base !== 2) begin n_fail++; $display("FAIL csum_we_pulses got %0d want 2", we_cnt - base); end
        n_chk++; if (mem[0] !== 32'h04030201) begin n_fail++; $display("FAIL csum_mem0 got %h want 04030201", mem[0]); end
        n_chk++; if (mem[1] !== 32'h08070605) begin n_fail++; $display("FAIL csum_mem1 got %h want 08070605", mem[1]); end
    endtask
`endif

    task automatic test_oversize;
        base = we_cnt;
        send_byte(8'hA5);
        n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL restart_hold got %b want 1", cpu_hold); end
        n_chk++; if (boot_done !== 1'b0 || boot_error !== 1'b0) begin n_fail++; $display("FAIL restart_flags got %b%b want 00", boot_done, boot_error); end
        n_chk++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL restart_words got %0d want 0", words_loaded); end
        send_byte(8'h01); send_byte(8'h04);
        n_chk++; if (boot_error !== 1'b1) begin n_fail++; $display("FAIL oversize_error got %b want 1", boot_error); end
        n_chk++; if (we_cnt !== base) begin n_fail++; $display("FAIL oversize_we got %0d want 0", we_cnt - base); end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        n_chk++; if (boot_error !== 1'b0) begin n_fail++; $display("FAIL maxlen_error got %b want 0", boot_error); end
        repeat (20) @(negedge clk);
        n_chk++; if (boot_error !== 1'b1) begin n_fail++; $display("FAIL maxlen_timeout got %b want 1", boot_error); end
    endtask

    task automatic test_zero_len;
        base = we_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        n_chk++; if (boot_done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_done got done=%b hold=%b want 1 0", boot_done, cpu_hold); end
        n_chk++; if (words_loaded !== 16'd0 || we_cnt !== base) begin n_fail++; $display("FAIL zero_words got %0d/%0d want 0/0", words_loaded, we_cnt - base); end
    endtask

    task automatic test_timeout;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        repeat (10) @(negedge clk);
        n_chk++; if (boot_error !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", boot_error); end
        repeat (10) @(negedge clk);
        n_chk++; if (boot_error !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL timeout_error got err=%b hold=%b want 1 1", boot_error, cpu_hold); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h44);
`endif
        n_chk++; if (boot_done !== 1'b1 || boot_error !== 1'b0) begin n_fail++; $display("FAIL timeout_recover got done=%b err=%b want 1 0", boot_done, boot_error); end
        n_chk++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL timeout_words got %0d want 1", words_loaded); end
        n_chk++; if (mem[0] !== 32'h11223344) begin n_fail++; $display("FAIL timeout_mem0 got %h want 11223344", mem[0]); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (cpu_hold !== 1'b1 || boot_done !== 1'b0 || boot_error !== 1'b0) begin n_fail++; $display("FAIL mid_flags got %b%b%b want 100", cpu_hold, boot_done, boot_error); end
        n_chk++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0) begin n_fail++; $display("FAIL mid_port got %b %h %h want 0 0 0", imem_we, imem_addr, imem_wdata); end
        n_chk++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL mid_words got %0d want 0", words_loaded); end
        rst = 1'b1;
        base = we_cnt;
        send_byte(8'h5A); send_byte(8'h00);
        n_chk++; if (we_cnt !== base || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_garbage got we=%0d hold=%b want 0 1", we_cnt - base, cpu_hold); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h04);
`endif
        n_chk++; if (mem[0] !== 32'h04030201 || imem_addr !== 10'd0) begin n_fail++; $display("FAIL mid_clean got %h@%h want 04030201@000", mem[0], imem_addr); end
        n_chk++; if (boot_done !== 1'b1 || words_loaded !== 16'd1) begin n_fail++; $display("FAIL mid_done got done=%b words=%0d want 1 1", boot_done, words_loaded); end
    endtask

`ifndef BOOT_CHECKSUM_EN
    task automatic test_direct_done;
        base = we_cnt;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        n_chk++; if (boot_done !== 1'b1 || we_cnt !== base) begin n_fail++; $display("FAIL done_garbage got done=%b we=%0d want 1 0", boot_done, we_cnt - base); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        @(negedge clk);
        rx_data = 8'hDD;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        n_chk++; if (imem_we !== 1'b1 || imem_wdata !== 32'hDDCCBBAA || imem_addr !== 10'd0) begin n_fail++; $display("FAIL direct_we got %b %h@%h want 1 ddccbbaa@000", imem_we, imem_wdata, imem_addr); end
        n_chk++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL direct_early_done got %b want 0", boot_done); end
        @(negedge clk);
        n_chk++; if (boot_done !== 1'b1 || cpu_hold !== 1'b0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL direct_done got done=%b hold=%b we=%b want 1 0 0", boot_done, cpu_hold, imem_we); end
        n_chk++; if (words_loaded !== 16'd1) begin n_fail++; $display("FAIL direct_words got %0d want 1", words_loaded); end
    endtask
`endif

    initial begin
        test_reset;
        test_load;
`ifdef BOOT_CHECKSUM_EN
        test_bad_csum;
`endif
        test_oversize;
        test_zero_len;
        test_timeout;
        test_reset_mid;
`ifndef BOOT_CHECKSUM_EN
        test_direct_done;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
